// File: rtl/s2_kes_sched.sv
// Round-robin scheduler sharing one t=2 KES engine between N_LANE syndrome lanes.
// Each lane has a one-entry holding register; results come back tagged with the lane index.

module s2_kes_hold (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        deq,
    input  logic [31:0] din,
    output logic        full,
    output logic [31:0] dout
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (deq) begin
            full <= 1'b0;
        end
    end
endmodule

module s2_kes_sched #(
    parameter int N_LANE  = 2,
    parameter int LANE_W  = 1,
    parameter int KES_TMO = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_LANE-1:0]     syn_valid,
    output logic [N_LANE-1:0]     syn_ready,
    input  logic [32*N_LANE-1:0]  syn_data,
    output logic                  kes_ena,
    output logic [7:0]            kes_syn0,
    output logic [7:0]            kes_syn1,
    output logic [7:0]            kes_syn2,
    output logic [7:0]            kes_syn3,
    input  logic                  kes_done,
    input  logic [7:0]            kes_lambda0,
    input  logic [7:0]            kes_lambda1,
    input  logic [7:0]            kes_lambda2,
    input  logic [7:0]            kes_omega0,
    input  logic [7:0]            kes_omega1,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [LANE_W-1:0]     res_lane,
    output logic [7:0]            res_lambda0,
    output logic [7:0]            res_lambda1,
    output logic [7:0]            res_lambda2,
    output logic [7:0]            res_omega0,
    output logic [7:0]            res_omega1,
    output logic                  res_err_free,
    output logic                  res_fail,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESULT} state_t;

    typedef struct packed {
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] l2;
        logic [7:0] o0;
        logic [7:0] o1;
        logic       err_free;
        logic       fail;
    } res_t;

    state_t                   state;
    res_t                     res;
    logic [LANE_W-1:0]        ptr, ptr_nxt, gnt_idx, idx_l, tag;
    logic [7:0]               cnt;
    logic [31:0]              wsyn, sel_syn;
    logic [N_LANE-1:0]        full, grant;
    logic [N_LANE-1:0][31:0]  syn_arr, hold_data;
    logic                     any;
    int                       idx;

    assign syn_arr = syn_data;

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        s2_kes_hold u_hold (
            .clk  (clk),
            .rstn (rstn),
            .load (syn_valid[i] & syn_ready[i]),
            .deq  (grant[i]),
            .din  (syn_arr[i]),
            .full (full[i]),
            .dout (hold_data[i])
        );
        assign syn_ready[i] = !full[i] | grant[i];
    end

    // First full lane at or after the pointer, wrapping; grant only asserts in IDLE.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        idx     = 0;
        idx_l   = '0;
        for (int k = 0; k < N_LANE; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_LANE) idx = idx - N_LANE;
            idx_l = LANE_W'(idx);
            if (!any && full[idx_l]) begin
                any     = 1'b1;
                gnt_idx = idx_l;
            end
        end
        if (state == S_IDLE && any) grant[gnt_idx] = 1'b1;
    end

    assign ptr_nxt = (gnt_idx == LANE_W'(N_LANE-1)) ? '0 : gnt_idx + 1'b1;
    assign sel_syn = hold_data[gnt_idx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            ptr   <= '0;
            tag   <= '0;
            cnt   <= '0;
            wsyn  <= '0;
            res   <= '0;
        end else begin
            case (state)
                S_IDLE: if (any) begin
                    ptr  <= ptr_nxt;
                    tag  <= gnt_idx;
                    wsyn <= sel_syn;
                    if (sel_syn == '0) begin
                        res   <= '{l0: 8'h01, l1: 8'h00, l2: 8'h00, o0: 8'h00, o1: 8'h00,
                                   err_free: 1'b1, fail: 1'b0};
                        state <= S_RESULT;
                    end else begin
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    // A completion on the final timeout cycle still counts as success.
                    if (kes_done) begin
                        res   <= '{l0: kes_lambda0, l1: kes_lambda1, l2: kes_lambda2,
                                   o0: kes_omega0, o1: kes_omega1, err_free: 1'b0, fail: 1'b0};
                        state <= S_RESULT;
                    end else if (cnt == 8'(KES_TMO-1)) begin
                        res   <= '{l0: 8'h00, l1: 8'h00, l2: 8'h00, o0: 8'h00, o1: 8'h00,
                                   err_free: 1'b0, fail: 1'b1};
                        state <= S_RESULT;
                    end
                end
                S_RESULT: if (res_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign kes_ena      = (state == S_LAUNCH);
    assign res_valid    = (state == S_RESULT);
    assign kes_syn0     = wsyn[7:0];
    assign kes_syn1     = wsyn[15:8];
    assign kes_syn2     = wsyn[23:16];
    assign kes_syn3     = wsyn[31:24];
    assign res_lane     = tag;
    assign res_lambda0  = res.l0;
    assign res_lambda1  = res.l1;
    assign res_lambda2  = res.l2;
    assign res_omega0   = res.o0;
    assign res_omega1   = res.o1;
    assign res_err_free = res.err_free;
    assign res_fail     = res.fail;
endmodule

// File: tb/tb_s2_kes_sched.sv
// Directed bench for s2_kes_sched: KES path, round-robin order, bypass, watchdog,
// result back-pressure with refill, and mid-run reset.

module tb_s2_kes_sched;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  syn_valid, syn_ready;
    logic [63:0] syn_data;
    logic        kes_ena;
    logic [7:0]  kes_syn0, kes_syn1, kes_syn2, kes_syn3;
    logic        kes_done = 1'b0;
    logic [7:0]  kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
    logic        res_valid, res_ready;
    logic [0:0]  res_lane;
    logic [7:0]  res_lambda0, res_lambda1, res_lambda2, res_omega0, res_omega1;
    logic        res_err_free, res_fail, busy;

    int          cyc = 0;
    int          ena_cnt = 0;
    int          ena_cyc = 0;
    int          done_cyc = 0;
    int          eng_delay = 0;
    logic [31:0] eng_syn = '0;
    logic [31:0] done_syn = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    s2_kes_sched #(.N_LANE(2), .LANE_W(1), .KES_TMO(15)) dut (
        .clk(clk), .rstn(rstn),
        .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data),
        .kes_ena(kes_ena), .kes_syn0(kes_syn0), .kes_syn1(kes_syn1),
        .kes_syn2(kes_syn2), .kes_syn3(kes_syn3),
        .kes_done(kes_done), .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1),
        .kes_lambda2(kes_lambda2), .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
        .res_valid(res_valid), .res_ready(res_ready), .res_lane(res_lane),
        .res_lambda0(res_lambda0), .res_lambda1(res_lambda1), .res_lambda2(res_lambda2),
        .res_omega0(res_omega0), .res_omega1(res_omega1),
        .res_err_free(res_err_free), .res_fail(res_fail), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (kes_ena) ena_cnt <= ena_cnt + 1;

    // Engine model: pulse kes_done eng_delay cycles after kes_ena (0 = never).
    always begin
        @(negedge clk);
        if (kes_ena) begin
            eng_syn = {kes_syn3, kes_syn2, kes_syn1, kes_syn0};
            ena_cyc = cyc;
            if (eng_delay > 0) begin
                repeat (eng_delay) @(negedge clk);
                done_syn = {kes_syn3, kes_syn2, kes_syn1, kes_syn0};
                done_cyc = cyc;
                kes_done = 1'b1;
                @(negedge clk);
                kes_done = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        syn_valid = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic offer(input logic [1:0] m, input logic [31:0] d0, input logic [31:0] d1,
                         output int c0);
        c0 = cyc;
        syn_data = {d1, d0};
        syn_valid = m;
        @(negedge clk);
        syn_valid = '0;
    endtask

    task automatic wait_res(input int bound, output int rc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < bound);
        chk("res_wait", res_valid, 1'b1);
        rc = cyc;
    endtask

    task automatic set_eng(input logic [39:0] v);
        {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1} = v;
    endtask

    function automatic logic [39:0] res_lo();
        return {res_lambda0, res_lambda1, res_lambda2, res_omega0, res_omega1};
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int c0, rc, e0, a, stable, rdy0_low;
        logic [42:0] snap;
        syn_data = '0;
        res_ready = 1'b1;
        set_eng(40'h0);
        do_reset();

        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_kes_ena", kes_ena, 1'b0);
        chk("rst_syn_ready", syn_ready, 2'b11);
        chk("rst_res_lambda", res_lo(), 40'h0);

        // KES path on lane 0
        eng_delay = 5;
        set_eng(40'h11_22_33_44_55);
        e0 = ena_cnt;
        offer(2'b01, 32'h04030201, 32'h0, c0);
        wait_res(40, rc);
        chk("t1_ena_cycle", ena_cyc, c0 + 2);
        chk("t1_kes_syn", eng_syn, 32'h04030201);
        chk("t1_syn_stable", done_syn, 32'h04030201);
        chk("t1_res_cycle", rc, done_cyc + 1);
        chk("t1_res_abs", rc, c0 + 8);
        chk("t1_lane", res_lane, 1'b0);
        chk("t1_lo", res_lo(), 40'h11_22_33_44_55);
        chk("t1_flags", {res_err_free, res_fail}, 2'b00);
        @(negedge clk);
        chk("t1_one_ena", ena_cnt - e0, 1);
        chk("t1_idle", {busy, res_valid}, 2'b00);

        // Round robin from reset: 0,1,0,1
        do_reset();
        eng_delay = 2;
        for (int p = 0; p < 2; p++) begin
            offer(2'b11, 32'h0000_0A01, 32'h0000_0B02, c0);
            for (int r = 0; r < 2; r++) begin
                wait_res(30, rc);
                chk($sformatf("rr_lane_%0d_%0d", p, r), res_lane, r[0]);
            end
        end

        // Bypass on lane 1 (pointer is back at 0, lane 0 empty)
        @(negedge clk);
        e0 = ena_cnt;
        offer(2'b10, 32'h0, 32'h0, c0);
        wait_res(10, rc);
        chk("byp_cycle", rc, c0 + 2);
        chk("byp_lane", res_lane, 1'b1);
        chk("byp_lo", res_lo(), 40'h01_00_00_00_00);
        chk("byp_flags", {res_err_free, res_fail}, 2'b10);
        @(negedge clk);
        chk("byp_no_ena", ena_cnt - e0, 0);

        // Watchdog: engine never completes
        eng_delay = 0;
        set_eng(40'hAA_BB_CC_DD_EE);
        offer(2'b01, 32'h0000_0100, 32'h0, c0);
        repeat (3) @(negedge clk);
        chk("tmo_busy", busy, 1'b1);
        wait_res(40, rc);
        chk("tmo_cycle", rc, c0 + 18);
        chk("tmo_flags", {res_err_free, res_fail}, 2'b01);
        chk("tmo_lo", res_lo(), 40'h0);

        // Completion exactly on the last WAIT cycle
        @(negedge clk);
        eng_delay = 15;
        offer(2'b01, 32'h0000_0200, 32'h0, c0);
        wait_res(40, rc);
        chk("tmo_edge_cycle", rc, c0 + 18);
        chk("tmo_edge_flags", {res_err_free, res_fail}, 2'b00);
        chk("tmo_edge_lo", res_lo(), 40'hAA_BB_CC_DD_EE);

        // Back-pressure with lane 0 refilled while the result waits
        @(negedge clk);
        eng_delay = 3;
        set_eng(40'h01_02_03_04_05);
        res_ready = 1'b0;
        offer(2'b01, 32'h1111_1111, 32'h0, c0);
        wait_res(30, rc);
        chk("bp_res_cycle", rc, c0 + 6);
        chk("bp_refill_ready", syn_ready[0], 1'b1);
        set_eng(40'h0);
        snap = {res_lane, res_lo(), res_err_free, res_fail};
        syn_data = {32'h0, 32'h2222_2222};
        syn_valid = 2'b01;
        stable = 1;
        rdy0_low = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            syn_valid = '0;
            if (!res_valid || {res_lane, res_lo(), res_err_free, res_fail} !== snap) stable = 0;
            if (syn_ready[0]) rdy0_low = 0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_full_not_ready", rdy0_low, 1);
        chk("bp_snap_lo", snap[41:2], 40'h01_02_03_04_05);
        a = cyc;
        res_ready = 1'b1;
        set_eng(40'h21_22_23_24_25);
        @(negedge clk);
        chk("bp_grant_ready", syn_ready[0], 1'b1);
        chk("bp_accepted", res_valid, 1'b0);
        wait_res(30, rc);
        chk("bp_regrant_ena", ena_cyc, a + 2);
        chk("bp_new_data", eng_syn, 32'h2222_2222);
        chk("bp_new_lo", res_lo(), 40'h21_22_23_24_25);

        // Reset during WAIT, with lane 1 also holding data
        @(negedge clk);
        eng_delay = 0;
        offer(2'b11, 32'h3333_3333, 32'h4444_4444, c0);
        repeat (4) @(negedge clk);
        chk("rw_busy_before", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_res_valid", res_valid, 1'b0);
        chk("rw_kes_ena", kes_ena, 1'b0);
        chk("rw_syn_ready", syn_ready, 2'b11);
        @(negedge clk);
        rstn = 1'b1;
        eng_delay = 2;
        set_eng(40'h31_32_33_34_35);
        e0 = ena_cnt;
        offer(2'b10, 32'h0, 32'h5566_7788, c0);
        wait_res(30, rc);
        chk("rw_post_lane", res_lane, 1'b1);
        chk("rw_post_syn", eng_syn, 32'h5566_7788);
        chk("rw_post_lo", res_lo(), 40'h31_32_33_34_35);
        stable = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) stable++;
        end
        chk("rw_no_stale_res", stable, 0);
        chk("rw_one_ena", ena_cnt - e0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
